// File: rtl/reg_file_alu_if.sv
// Bus between the CPU control path and the register-file/ALU datapath.
// master: drives read/write addresses, immediate, ALU op, write enable and operand select;
//         sees ALUResult, Zero and cpu_out.
// slave : the reg_file_alu datapath.
interface reg_file_alu_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] immediate;
  logic [1:0]        ALUControl;
  logic              write_enable;
  logic              ALUSrc;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] cpu_out;
  logic              Zero;

  modport master (
    output RA1, RA2, WA, immediate, ALUControl, write_enable, ALUSrc,
    input  ALUResult, cpu_out, Zero
  );

  modport slave (
    input  RA1, RA2, WA, immediate, ALUControl, write_enable, ALUSrc,
    output ALUResult, cpu_out, Zero
  );
endinterface

// File: rtl/reg_file_alu.sv
// Register file (2**ADDR_W x DATA_W, two async read ports, one sync write port)
// fused with a 2-bit-opcode ALU whose result is the write-back data:
//   R[WA] <= R[RA1] op (ALUSrc ? immediate : R[RA2])
// Ports:
//   CLK  - system clock, writes on rising edge
//   RST  - asynchronous active-high reset, clears every register
//   bus  - reg_file_alu_if slave: addresses, immediate, op, write enable,
//          operand select in; ALUResult, Zero, cpu_out (= highest register) out
module reg_file_alu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic            CLK,
  input  logic            RST,
  reg_file_alu_if.slave   bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam int OUT_REG = NREGS - 1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;

  // No write bypass: readers see the old value until the edge commits.
  assign rd1  = regs[bus.RA1];
  assign rd2  = regs[bus.RA2];
  assign op_b = bus.ALUSrc ? bus.immediate : rd2;

  always_comb begin
    alu_result = '0;
    case (bus.ALUControl)
      2'b00:   alu_result = rd1 + op_b;
      2'b01:   alu_result = rd1 - op_b;
      2'b10:   alu_result = rd1 & op_b;
      default: alu_result = rd1 | op_b;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.write_enable) begin
      regs[bus.WA] <= alu_result;
    end
  end

  assign bus.ALUResult = alu_result;
  assign bus.Zero      = (alu_result == '0);
  assign bus.cpu_out   = regs[OUT_REG];
endmodule

// File: tb/tb_reg_file_alu.sv
module tb_reg_file_alu;
  logic clk;
  logic rst;

  reg_file_alu_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  reg_file_alu #(.DATA_W(8), .ADDR_W(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int model_r [16];

  typedef struct {
    int ra1; int ra2; int wa; int imm; int op; int we; int src;
    int exp_res; int exp_zero;
  } vec_t;

  vec_t vecs [8];

  function automatic int model_alu(int a, int b, int op);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic drive(input int ra1, input int ra2, input int wa, input int imm,
                       input int op, input int we, input int src);
    bus.RA1          = 4'(ra1);
    bus.RA2          = 4'(ra2);
    bus.WA           = 4'(wa);
    bus.immediate    = 8'(imm);
    bus.ALUControl   = 2'(op);
    bus.write_enable = 1'(we);
    bus.ALUSrc       = 1'(src);
  endtask

  // Expected ALU output for the currently driven inputs, from the model registers.
  function automatic int model_now();
    int b;
    b = bus.ALUSrc ? int'(bus.immediate) : model_r[int'(bus.RA2)];
    return model_alu(model_r[int'(bus.RA1)], b, int'(bus.ALUControl));
  endfunction

  task automatic tick();
    int res;
    int wa;
    int we;
    res = model_now();
    wa  = int'(bus.WA);
    we  = int'(bus.write_enable);
    @(posedge clk);
    #1;
    if (we != 0 && !rst) model_r[wa] = res;
  endtask

  // Observe a register by OR-ing it with itself.
  task automatic read_reg(input int addr, output int val);
    drive(addr, addr, 0, 0, 3, 0, 0);
    #1;
    val = int'(bus.ALUResult);
  endtask

  initial begin
    int v;
    int exp;
    for (int i = 0; i < 16; i++) model_r[i] = 0;

    // Reset with no clock edge yet.
    rst = 1'b1;
    drive(3, 3, 0, 0, 0, 0, 0);
    #2;
    check("reset_cpu_out", int'(bus.cpu_out), 0);
    check("reset_alu", int'(bus.ALUResult), 0);
    check("reset_zero", int'(bus.Zero), 1);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{0, 0, 1, 5,    0, 1, 1, 5,    0};
    vecs[1] = '{0, 0, 2, 7,    0, 1, 1, 7,    0};
    vecs[2] = '{1, 2, 0, 0,    0, 0, 0, 12,   0};
    vecs[3] = '{1, 2, 0, 0,    1, 0, 0, 8'hFE, 0};
    vecs[4] = '{1, 2, 0, 0,    2, 0, 0, 8'h05, 0};
    vecs[5] = '{1, 2, 0, 0,    3, 0, 0, 8'h07, 0};
    vecs[6] = '{0, 0, 1, 8'hFF, 0, 1, 1, 8'hFF, 0};
    vecs[7] = '{1, 0, 0, 1,    0, 0, 1, 0,    1};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].ra1, vecs[i].ra2, vecs[i].wa, vecs[i].imm,
            vecs[i].op, vecs[i].we, vecs[i].src);
      #1;
      check($sformatf("vec%0d_result", i), int'(bus.ALUResult), vecs[i].exp_res);
      check($sformatf("vec%0d_zero", i), int'(bus.Zero), vecs[i].exp_zero);
      tick();
    end

    // write_enable=0 holds R5 at 0 while ALUResult=13 targets it.
    for (int k = 0; k < 3; k++) begin
      drive(2, 0, 5, 6, 0, 0, 1);
      #1;
      check("hold_result", int'(bus.ALUResult), 13);
      tick();
      read_reg(5, v);
      check("hold_r5", v, 0);
    end
    drive(2, 0, 5, 6, 0, 1, 1);
    tick();
    read_reg(5, v);
    check("enable_r5", v, 13);

    // cpu_out tracks R15 only.
    drive(0, 0, 15, 15, 0, 1, 1);
    tick();
    check("cpu_out_w15", int'(bus.cpu_out), 15);
    drive(0, 0, 14, 9, 0, 1, 1);
    tick();
    check("cpu_out_w14", int'(bus.cpu_out), 15);
    read_reg(14, v);
    check("r14", v, 9);

    // Read-during-write increment of R3.
    drive(0, 0, 3, 1, 0, 1, 1);
    tick();
    drive(3, 0, 3, 1, 0, 1, 1);
    #1;
    check("rdw_before", int'(bus.ALUResult), 2);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rdw_after", int'(bus.ALUResult), k + 3);
    end

    // Async reset between edges, with a write pending across an edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_cpu_out", int'(bus.cpu_out), 0);
    check("async_r3_path", int'(bus.ALUResult), 1);
    @(posedge clk);
    #1;
    check("rst_discards_write", int'(bus.ALUResult), 1);
    read_reg(3, v);
    check("async_r3", v, 0);
    read_reg(14, v);
    check("async_r14", v, 0);
    for (int i = 0; i < 16; i++) model_r[i] = 0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      drive(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
            (k % 17 == 0) ? 0 : int'($urandom_range(255)), int'($urandom_range(3)),
            int'($urandom_range(1)), int'($urandom_range(1)));
      #1;
      exp = model_now();
      check("rand_result", int'(bus.ALUResult), exp);
      check("rand_zero", int'(bus.Zero), (exp == 0) ? 1 : 0);
      tick();
      check("rand_cpu_out", int'(bus.cpu_out), model_r[15]);
    end
    for (int i = 0; i < 16; i++) begin
      read_reg(i, v);
      check($sformatf("final_r%0d", i), v, model_r[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reg_file_alu.md
Name: reg_file_alu

Overview:
- 16-entry × 8-bit register file with two combinational read ports and one synchronous write port, coupled to a 2-bit-opcode 8-bit ALU.
- The ALU result is the write-back data, so one cycle performs `R[WA] <= R[RA1] op (ALUSrc ? immediate : R[RA2])`.
- Sits as the datapath core of the simple CPU.
- Register 15 is the architectural output register, exposed on cpu_out.

Parameters:
- DATA_W, 8, register/ALU data width.
- ADDR_W, 4, register address width; register count = 2**ADDR_W = 16.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- RA1  input  4  read address A; selects ALU operand A.
- RA2  input  4  read address B; selects ALU operand B when ALUSrc=0.
- WA  input  4  write address.
- immediate  input  8  immediate operand B when ALUSrc=1.
- ALUControl  input  2  ALU operation select.
- write_enable  input  1  write ALUResult into R[WA] at rising CLK.
- ALUSrc  input  1  operand B select: 0 = R[RA2], 1 = immediate.
- ALUResult  output  8  combinational ALU result.
- cpu_out  output  8  current contents of R15.
- Zero  output  1  high when ALUResult == 0.

Behaviour:
- Clocking and reset:
  - One clock: CLK.
  - Reset is asynchronous and active-high on RST.
  - While RST=1, all 16 registers are 0. Outputs follow the reset state: RD1 = RD2 = 0, so for ALUSrc=0 ALUResult=0, Zero=1, cpu_out=0.
  - RST asserted mid-operation clears all registers immediately, with no clock needed. A write in the same cycle as RST is discarded.
- Reads:
  - Combinational and asynchronous: RD1 = R[RA1], RD2 = R[RA2].
  - RA1 may equal RA2.
- Operand B mux: B = ALUSrc ? immediate : RD2.
- ALU (combinational, all modulo 256, no flags other than Zero):
  - 00 ADD: A+B, carry discarded.
  - 01 SUB: A−B, two's complement wrap (e.g. 3−5 = 0xFE).
  - 10 AND: A&B.
  - 11 OR: A|B.
- Zero = (ALUResult == 8'h00), combinational. A result that is 0 only because of wrap (e.g. 0xFF+0x01) still sets Zero=1.
- Write:
  - On rising CLK with write_enable=1 and RST=0: R[WA] <= ALUResult as sampled just before the edge.
  - All 16 registers are writable, including R0.
  - write_enable=0: no register changes.
- Read-during-write: a read of the address being written returns the old value until the edge, and the new value after it. No bypass.
  - Consequence: when WA == RA1 (or RA2 with ALUSrc=0), ALUResult changes after the edge. This is a combinational path only, not a loop; only one write occurs per edge.
- cpu_out = R[15], combinational from register storage. It updates immediately after a write to WA=15.
- Latency: ALUResult/Zero are combinational (0 cycles). Write-back is visible on the read ports one edge later.
- No X propagation from storage: all registers are defined from reset onward.

Test Plan:
- Reset: pulse RST with CLK idle → cpu_out=0; with RA1=RA2=3, ALUSrc=0, ALUControl=00 → ALUResult=0, Zero=1. Assert RST between edges after a write → registers cleared without a clock edge.
- Immediate load and write:
  - RA1=0, ALUSrc=1, immediate=5, ADD, WA=1, write_enable=1, one edge → R1=5.
  - Repeat with immediate=7, WA=2 → R2=7.
  - RA1=1, RA2=2, ALUSrc=0, ADD → ALUResult=12, Zero=0.
- Opcode sweep with R1=5, R2=7: SUB → 0xFE; AND → 0x05; OR → 0x07. Then R1=0xFF, immediate=0x01, ADD → 0x00, Zero=1.
- write_enable=0: hold WA=5, ALUResult=13 across 3 edges → R5 stays 0 (read via RA2=5). Enable → R5=13 after the next edge only.
- cpu_out: write immediate=15 to WA=15 → cpu_out=15 right after the edge. Write to WA=14 → cpu_out unchanged.
- Read-during-write, with R3=1:
  - RA1=3, WA=3, ALUSrc=1, immediate=1, ADD, write_enable=1.
  - ALUResult=2 before the edge; R3=2 and ALUResult=3 after it.
  - R3 increments by exactly one per edge.
